// File: rtl/simple_single_cpu.sv
// simple_single_cpu: single-cycle 32-bit MIPS-subset core.
// Holds PC, register file, ALU, decode, plus IM and DM instances.

module instr_mem #(
    parameter int IM_WORDS = 256
) (
    input  logic [31:0] pc_addr_i,
    output logic [31:0] instr_o
);
    localparam int IAW = $clog2(IM_WORDS);

    logic [31:0] Instr_Mem [0:IM_WORDS-1];
    logic        in_range;
    logic        unused_lsb;

    assign unused_lsb = ^pc_addr_i[1:0];
    assign in_range   = pc_addr_i[31:2] < 30'(IM_WORDS);

    // Word-indexed combinational fetch; past the end reads as a NOP
    always_comb begin
        instr_o = '0;
        if (in_range) instr_o = Instr_Mem[pc_addr_i[IAW+1:2]];
    end
endmodule

module data_mem #(
    parameter int DM_WORDS = 128
) (
    input  logic        clk,
    input  logic [31:0] addr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int DAW = $clog2(DM_WORDS);

    logic [31:0] Data_Mem [0:DM_WORDS-1];
    logic        in_range;
    logic        unused_lsb;

    assign unused_lsb = ^addr_i[1:0];
    assign in_range   = addr_i[31:2] < 30'(DM_WORDS);

    // Combinational read, zero when not strobed or out of range
    always_comb begin
        rdata = '0;
        if (MemRead_i && in_range) rdata = Data_Mem[addr_i[DAW+1:2]];
    end

    // Contents survive reset; out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (MemWrite_i && in_range) Data_Mem[addr_i[DAW+1:2]] <= wdata;
    end
endmodule

module simple_single_cpu #(
    parameter int IM_WORDS = 256,
    parameter int DM_WORDS = 128
) (
    input  logic clk_i,
    input  logic rst_n
);
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_t;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] reg_file [0:31];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        is_r;

    logic        reg_write;
    logic        dst_rd;
    logic        use_imm;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        jump_reg;
    logic        link;
    alu_op_t     alu_op;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] dm_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        dm_read;
    logic        dm_write;
    logic        branch_taken;

    instr_mem #(.IM_WORDS(IM_WORDS)) IM (
        .pc_addr_i (pc),
        .instr_o   (instr)
    );

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];
    assign is_r   = op == 6'h00;

    // Decode: undefined encodings fall through with every strobe low
    always_comb begin
        reg_write  = 1'b0;
        dst_rd     = 1'b0;
        use_imm    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        link       = 1'b0;
        alu_op     = ALU_ADD;
        unique case (1'b1)
            is_r && funct == 6'h20: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
            end
            is_r && funct == 6'h22: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
                alu_op    = ALU_SUB;
            end
            is_r && funct == 6'h24: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
                alu_op    = ALU_AND;
            end
            is_r && funct == 6'h25: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
                alu_op    = ALU_OR;
            end
            is_r && funct == 6'h2A: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
                alu_op    = ALU_SLT;
            end
            is_r && funct == 6'h00: begin
                reg_write = 1'b1;
                dst_rd    = 1'b1;
                alu_op    = ALU_SLL;
            end
            is_r && funct == 6'h08: begin
                jump_reg = 1'b1;
            end
            op == 6'h08: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
            end
            op == 6'h0A: begin
                reg_write = 1'b1;
                use_imm   = 1'b1;
                alu_op    = ALU_SLT;
            end
            op == 6'h23: begin
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            op == 6'h2B: begin
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            op == 6'h04: begin
                branch_eq = 1'b1;
            end
            op == 6'h05: begin
                branch_ne = 1'b1;
            end
            op == 6'h02: begin
                jump = 1'b1;
            end
            op == 6'h03: begin
                jump      = 1'b1;
                link      = 1'b1;
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rs_val  = (rs == 5'd0) ? '0 : reg_file[rs];
    assign rt_val  = (rt == 5'd0) ? '0 : reg_file[rt];
    assign imm_ext = {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rt_val;

    // ALU: wrap-around arithmetic, signed compare, shift of rt
    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_SLT: alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLL: alu_result = rt_val << shamt;
            default: alu_result = '0;
        endcase
    end

    // Memory strobes are forced low while the core is held in reset
    assign dm_read  = mem_read & rst_n;
    assign dm_write = mem_write & rst_n;

    data_mem #(.DM_WORDS(DM_WORDS)) DM (
        .clk        (clk_i),
        .addr_i     (alu_result),
        .MemRead_i  (dm_read),
        .MemWrite_i (dm_write),
        .wdata      (rt_val),
        .rdata      (dm_rdata)
    );

    assign pc_plus4     = pc + 32'd4;
    assign branch_taken = (branch_eq && rs_val == rt_val)
                       || (branch_ne && rs_val != rt_val);

    // Next-PC select: register jump, absolute jump, branch, fall-through
    always_comb begin
        pc_next = pc_plus4;
        unique case (1'b1)
            jump_reg:     pc_next = rs_val;
            jump:         pc_next = {pc_plus4[31:28], target, 2'b00};
            branch_taken: pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
            default:      pc_next = pc_plus4;
        endcase
    end

    assign wb_addr = link ? 5'd31 : (dst_rd ? rd : rt);
    assign wb_data = link ? pc_plus4 : (mem_to_reg ? dm_rdata : alu_result);

    // PC advances every edge, restart from zero on reset
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else        pc <= pc_next;
    end

    // Register file retires one write per edge; $0 is never written
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) reg_file[i] <= '0;
        end else if (reg_write && wb_addr != 5'd0) begin
            reg_file[wb_addr] <= wb_data;
        end
    end
endmodule

// File: tb/tb_simple_single_cpu.sv
// tb_simple_single_cpu: directed programs for the single-cycle core.
// Programs are poked into IM; state is probed hierarchically.

module tb_simple_single_cpu;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    simple_single_cpu #(.IM_WORDS(256), .DM_WORDS(128)) dut (
        .clk_i (clk_i),
        .rst_n (rst_n)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  r;
        logic [31:0] exp;
    } vec_t;

    vec_t alu_tab [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_r(input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] f_i(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] f_j(input logic [5:0] op,
        input logic [25:0] tg);
        return {op, tg};
    endfunction

    task automatic clear_im();
        for (int i = 0; i < 256; i++) dut.IM.Instr_Mem[i] = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] rf(input logic [4:0] r);
        return dut.reg_file[r];
    endfunction

    function automatic logic [31:0] pcv();
        return dut.pc;
    endfunction

    initial begin
        alu_tab[0] = '{"addi_pos", f_i(6'h08, 0, 1, 16'd5),    5'd1, 32'd5};
        alu_tab[1] = '{"addi_neg", f_i(6'h08, 0, 2, 16'hFFFD), 5'd2, 32'hFFFFFFFD};
        alu_tab[2] = '{"add",      f_r(1, 2, 3, 0, 6'h20),     5'd3, 32'd2};
        alu_tab[3] = '{"sub",      f_r(1, 2, 4, 0, 6'h22),     5'd4, 32'd8};
        alu_tab[4] = '{"and",      f_r(1, 2, 5, 0, 6'h24),     5'd5, 32'd5};
        alu_tab[5] = '{"or",       f_r(1, 2, 6, 0, 6'h25),     5'd6, 32'hFFFFFFFD};
        alu_tab[6] = '{"slt",      f_r(2, 1, 7, 0, 6'h2A),     5'd7, 32'd1};
        alu_tab[7] = '{"sll",      f_r(0, 1, 8, 4, 6'h00),     5'd8, 32'h50};
        alu_tab[8] = '{"slti",     f_i(6'h0A, 2, 9, 16'hFFFE), 5'd9, 32'd1};

        // Reset and fetch sequencing on the ALU program
        clear_im();
        for (int i = 0; i < 9; i++) dut.IM.Instr_Mem[i] = alu_tab[i].instr;
        hold_reset();
        chk("rst_pc", pcv(), 32'd0);
        chk("rst_r5", rf(5), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fetch_%0d", k), dut.IM.pc_addr_i, 32'(4 * k));
            step(1);
        end
        step(5);
        for (int i = 0; i < 9; i++)
            chk(alu_tab[i].name, rf(alu_tab[i].r), alu_tab[i].exp);

        // Strobes suppressed in reset even with lw at PC 0
        clear_im();
        dut.IM.Instr_Mem[0] = f_i(6'h23, 0, 2, 16'd8);
        hold_reset();
        chk("rst_r3_clr", rf(3), 32'd0);
        chk("rst_memread", 32'(dut.DM.MemRead_i), 32'd0);

        // Store then load back-to-back
        dut.IM.Instr_Mem[0] = f_i(6'h08, 0, 1, 16'h1234);
        dut.IM.Instr_Mem[1] = f_i(6'h2B, 0, 1, 16'd8);
        dut.IM.Instr_Mem[2] = f_i(6'h23, 0, 2, 16'd8);
        rst_n = 1'b1;
        #1;
        chk("addi_wr", 32'(dut.DM.MemWrite_i), 32'd0);
        chk("addi_rd", 32'(dut.DM.MemRead_i), 32'd0);
        step(1);
        chk("sw_addr", dut.DM.addr_i, 32'd8);
        chk("sw_wr", 32'(dut.DM.MemWrite_i), 32'd1);
        chk("sw_rd", 32'(dut.DM.MemRead_i), 32'd0);
        step(1);
        chk("lw_addr", dut.DM.addr_i, 32'd8);
        chk("lw_rd", 32'(dut.DM.MemRead_i), 32'd1);
        chk("lw_wr", 32'(dut.DM.MemWrite_i), 32'd0);
        step(1);
        chk("lw_data", rf(2), 32'h1234);
        chk("nop_rd", 32'(dut.DM.MemRead_i), 32'd0);
        chk("nop_wr", 32'(dut.DM.MemWrite_i), 32'd0);

        // Out-of-range access and DM persistence across reset
        clear_im();
        dut.IM.Instr_Mem[0] = f_i(6'h08, 0, 3, 16'h0055);
        dut.IM.Instr_Mem[1] = f_i(6'h2B, 0, 3, 16'h0200);
        dut.IM.Instr_Mem[2] = f_i(6'h23, 0, 4, 16'h0200);
        dut.IM.Instr_Mem[3] = f_i(6'h23, 0, 5, 16'd8);
        dut.IM.Instr_Mem[4] = f_i(6'h23, 0, 6, 16'd0);
        hold_reset();
        rst_n = 1'b1;
        step(5);
        chk("oor_src", rf(3), 32'h55);
        chk("oor_load", rf(4), 32'd0);
        chk("dm_keep", rf(5), 32'h1234);
        chk("no_wrap", rf(6) == 32'h55 ? 32'd1 : 32'd0, 32'd0);

        // Branches: beq taken, bne not taken, bne taken, self-loop
        clear_im();
        dut.IM.Instr_Mem[4]  = f_i(6'h04, 0, 0, 16'd2);
        dut.IM.Instr_Mem[5]  = f_i(6'h08, 0, 5, 16'd9);
        dut.IM.Instr_Mem[6]  = f_i(6'h08, 0, 5, 16'd9);
        dut.IM.Instr_Mem[7]  = f_i(6'h05, 0, 0, 16'd5);
        dut.IM.Instr_Mem[8]  = f_i(6'h08, 0, 1, 16'd1);
        dut.IM.Instr_Mem[9]  = f_i(6'h05, 1, 0, 16'd1);
        dut.IM.Instr_Mem[10] = f_i(6'h08, 0, 6, 16'd9);
        dut.IM.Instr_Mem[11] = f_i(6'h04, 0, 0, 16'hFFFF);
        hold_reset();
        rst_n = 1'b1;
        step(4);
        chk("pc_beq_at", pcv(), 32'h10);
        step(1);
        chk("beq_taken", pcv(), 32'h1C);
        step(1);
        chk("bne_eq", pcv(), 32'h20);
        step(1);
        chk("pc_addi", pcv(), 32'h24);
        step(1);
        chk("bne_taken", pcv(), 32'h2C);
        step(1);
        chk("self_loop1", pcv(), 32'h2C);
        step(3);
        chk("self_loop4", pcv(), 32'h2C);
        chk("skip_r5", rf(5), 32'd0);
        chk("skip_r6", rf(6), 32'd0);

        // jal / jr / j back to 0
        clear_im();
        dut.IM.Instr_Mem[0]  = f_i(6'h08, 0, 2, 16'd3);
        dut.IM.Instr_Mem[8]  = f_j(6'h03, 26'h10);
        dut.IM.Instr_Mem[9]  = f_i(6'h08, 2, 2, 16'd1);
        dut.IM.Instr_Mem[10] = f_j(6'h02, 26'h0);
        dut.IM.Instr_Mem[16] = f_r(31, 0, 0, 0, 6'h08);
        hold_reset();
        rst_n = 1'b1;
        step(8);
        chk("pc_jal_at", pcv(), 32'h20);
        step(1);
        chk("jal_pc", pcv(), 32'h40);
        chk("jal_link", rf(31), 32'h24);
        step(1);
        chk("jr_pc", pcv(), 32'h24);
        step(1);
        chk("after_jr", rf(2), 32'd4);
        step(1);
        chk("j_zero", pcv(), 32'd0);
        step(1);
        chk("restart_pc", pcv(), 32'd4);
        chk("restart_r2", rf(2), 32'd3);

        // $0 writes, undefined encodings, mid-run reset
        clear_im();
        dut.IM.Instr_Mem[0] = f_i(6'h08, 0, 0, 16'd7);
        dut.IM.Instr_Mem[1] = f_i(6'h3F, 0, 1, 16'h1234);
        dut.IM.Instr_Mem[2] = f_r(0, 0, 1, 0, 6'h3F);
        dut.IM.Instr_Mem[3] = f_i(6'h08, 0, 9, 16'd1);
        dut.IM.Instr_Mem[4] = f_i(6'h04, 0, 0, 16'hFFFF);
        hold_reset();
        rst_n = 1'b1;
        step(1);
        chk("r0_zero", rf(0), 32'd0);
        chk("pc_r0", pcv(), 32'd4);
        step(1);
        chk("undef_op_pc", pcv(), 32'd8);
        chk("undef_op_r1", rf(1), 32'd0);
        chk("undef_op_wr", 32'(dut.DM.MemWrite_i), 32'd0);
        step(1);
        chk("undef_fn_pc", pcv(), 32'd12);
        chk("undef_fn_r1", rf(1), 32'd0);
        step(1);
        chk("r9_set", rf(9), 32'd1);
        step(2);
        chk("loop_pc", pcv(), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc", pcv(), 32'd0);
        chk("async_r9", rf(9), 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        chk("rel_pc", pcv(), 32'd0);
        step(1);
        chk("rel_step", pcv(), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
